// File: rtl/digota_pkg.sv
// Shared types and helpers for the multi-channel digital-OTA output sequencer.
package digota_pkg;

  typedef enum logic [1:0] {
    HIZ  = 2'b00,
    DEAD = 2'b01,
    PUSH = 2'b10,
    PULL = 2'b11
  } state_t;

  localparam logic OPMOS_RST       = 1'b1;
  localparam logic ONMOS_RST       = 1'b0;
  localparam logic CMPMOS_RST      = 1'b1;
  localparam logic CMNMOS_RST      = 1'b0;
  localparam logic DEAD_ACTIVE_RST = 1'b0;

  // Drive target from synchronised, already-inverted (active-high) inputs.
  function automatic state_t decode_target(input logic oe_s, input logic inp, input logic inm);
    if (!oe_s) return HIZ;
    if (inp && !inm) return PUSH;
    if (!inp && inm) return PULL;
    return HIZ;
  endfunction

endpackage

// File: rtl/digota_channel.sv
// One OTA channel: input synchroniser, break-before-make FSM with dead-time
// counter, and registered gate controls.
module digota_channel
  import digota_pkg::*;
#(
  parameter int DT_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inpb,
  input  logic            inmb,
  input  logic            oe,
  input  logic [DT_W-1:0] dead_time,
  output logic            opmos,
  output logic            onmos,
  output logic            cmpmos,
  output logic            cmnmos,
  output logic            dead_active
);

  logic [SYNC_STAGES-1:0] inpb_q;
  logic [SYNC_STAGES-1:0] inmb_q;
  logic [SYNC_STAGES-1:0] oe_q;

  // Sync flops reset to the idle (deasserted) level so no target is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inpb_q <= '1;
      inmb_q <= '1;
      oe_q   <= '0;
    end else begin
      inpb_q <= {inpb_q[SYNC_STAGES-2:0], inpb};
      inmb_q <= {inmb_q[SYNC_STAGES-2:0], inmb};
      oe_q   <= {oe_q[SYNC_STAGES-2:0], oe};
    end
  end

  logic   oe_s, inp, inm;
  state_t target;

  assign oe_s   = oe_q[SYNC_STAGES-1];
  assign inp    = ~inpb_q[SYNC_STAGES-1];
  assign inm    = ~inmb_q[SYNC_STAGES-1];
  assign target = decode_target(oe_s, inp, inm);

  state_t          state, state_n;
  state_t          tgt, tgt_n;
  logic [DT_W-1:0] count, count_n;

  // Releases go straight to HIZ; every new drive goes through DEAD first.
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    count_n = count;
    case (state)
      HIZ: begin
        if (target != HIZ) begin
          state_n = DEAD;
          tgt_n   = target;
          count_n = dead_time;
        end
      end
      DEAD: begin
        if (target == HIZ) begin
          state_n = HIZ;
        end else if (target != tgt) begin
          tgt_n   = target;
          count_n = dead_time;
        end else if (count == '0) begin
          state_n = tgt;
        end else begin
          count_n = count - DT_W'(1);
        end
      end
      PUSH, PULL: begin
        if (target == HIZ) begin
          state_n = HIZ;
        end else if (target != state) begin
          state_n = DEAD;
          tgt_n   = target;
          count_n = dead_time;
        end
      end
      default: state_n = HIZ;
    endcase
  end

  // Gate controls are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HIZ;
      tgt         <= HIZ;
      count       <= '0;
      opmos       <= OPMOS_RST;
      onmos       <= ONMOS_RST;
      cmpmos      <= CMPMOS_RST;
      cmnmos      <= CMNMOS_RST;
      dead_active <= DEAD_ACTIVE_RST;
    end else begin
      state       <= state_n;
      tgt         <= tgt_n;
      count       <= count_n;
      opmos       <= (state_n != PUSH);
      onmos       <= (state_n == PULL);
      dead_active <= (state_n == DEAD);
      cmpmos      <= ~(oe_s & ~inp & ~inm);
      cmnmos      <= oe_s & inp & inm;
    end
  end

endmodule

// File: rtl/digota_array.sv
// Array of independent OTA output channels sharing one clock, reset and dead-time setting.
module digota_array #(
  parameter int CHANNELS    = 4,
  parameter int DT_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] inpb,
  input  logic [CHANNELS-1:0] inmb,
  input  logic [CHANNELS-1:0] oe,
  input  logic [DT_W-1:0]     dead_time,
  output logic [CHANNELS-1:0] opmos,
  output logic [CHANNELS-1:0] onmos,
  output logic [CHANNELS-1:0] cmpmos,
  output logic [CHANNELS-1:0] cmnmos,
  output logic [CHANNELS-1:0] dead_active
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    digota_channel #(
      .DT_W        (DT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .inpb        (inpb[i]),
      .inmb        (inmb[i]),
      .oe          (oe[i]),
      .dead_time   (dead_time),
      .opmos       (opmos[i]),
      .onmos       (onmos[i]),
      .cmpmos      (cmpmos[i]),
      .cmnmos      (cmnmos[i]),
      .dead_active (dead_active[i])
    );
  end

endmodule

// File: tb/tb_digota_array.sv
// Bench for digota_array: steady-state vector table, timed corner sequences,
// and random traffic against a cycle-level behavioural model.
module tb_digota_array;

  localparam int CH   = 4;
  localparam int DT_W = 4;
  localparam int SS   = 2;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   inpb, inmb, oe;
  logic [DT_W-1:0] dead_time;
  logic [CH-1:0]   opmos, onmos, cmpmos, cmnmos, dead_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CH-1:0] inpb;
    logic [CH-1:0] inmb;
    logic [CH-1:0] oe;
  } in_t;

  typedef struct {
    logic [CH-1:0] inpb, inmb, oe;
    logic [CH-1:0] op, on, cmp, cmn;
  } vec_t;

  // Model: inputs delayed SS edges, then per channel what is driven (0 none,
  // 1 push, 2 pull), what is pending, and how many both-off edges remain.
  in_t           hist[$];
  int            m_drive[CH];
  int            m_pend[CH];
  int            m_wait[CH];
  logic [CH-1:0] m_cmp, m_cmn;
  int            last_on[CH];
  int            gap[CH];

  digota_array #(.CHANNELS(CH), .DT_W(DT_W), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inpb        (inpb),
    .inmb        (inmb),
    .oe          (oe),
    .dead_time   (dead_time),
    .opmos       (opmos),
    .onmos       (onmos),
    .cmpmos      (cmpmos),
    .cmnmos      (cmnmos),
    .dead_active (dead_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int s = 0; s < SS; s++) begin
      in_t r;
      r.inpb = '1;
      r.inmb = '1;
      r.oe   = '0;
      hist.push_back(r);
    end
    for (int c = 0; c < CH; c++) begin
      m_drive[c] = 0;
      m_pend[c]  = 0;
      m_wait[c]  = 0;
      last_on[c] = 0;
      gap[c]     = 0;
    end
    m_cmp = '1;
    m_cmn = '0;
  endfunction

  function automatic void model_step();
    in_t s, cur;
    s        = hist.pop_front();
    cur.inpb = inpb;
    cur.inmb = inmb;
    cur.oe   = oe;
    hist.push_back(cur);
    for (int c = 0; c < CH; c++) begin
      int   t;
      logic p, m, e;
      e = s.oe[c];
      p = !s.inpb[c];
      m = !s.inmb[c];
      t = !e ? 0 : (p && !m) ? 1 : (!p && m) ? 2 : 0;
      m_cmp[c] = !(e && !p && !m);
      m_cmn[c] = e && p && m;
      if (t == 0) begin
        m_drive[c] = 0;
        m_pend[c]  = 0;
      end else if (m_drive[c] == t) begin
        m_pend[c] = 0;
      end else if (m_pend[c] == t) begin
        m_wait[c] = m_wait[c] - 1;
        if (m_wait[c] == 0) begin
          m_drive[c] = t;
          m_pend[c]  = 0;
        end
      end else begin
        m_drive[c] = 0;
        m_pend[c]  = t;
        m_wait[c]  = int'(dead_time) + 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [CH-1:0] e_op, e_on, e_da;
    for (int c = 0; c < CH; c++) begin
      e_op[c] = (m_drive[c] != 1);
      e_on[c] = (m_drive[c] == 2);
      e_da[c] = (m_pend[c] != 0);
    end
    chk("model_opmos", 32'(opmos), 32'(e_op));
    chk("model_onmos", 32'(onmos), 32'(e_on));
    chk("model_dead_active", 32'(dead_active), 32'(e_da));
    chk("model_cmpmos", 32'(cmpmos), 32'(m_cmp));
    chk("model_cmnmos", 32'(cmnmos), 32'(m_cmn));
    for (int c = 0; c < CH; c++) begin
      chk("inv_push_pull_overlap", 32'(!opmos[c] && onmos[c]), 0);
      chk("inv_cm_overlap", 32'(!cmpmos[c] && cmnmos[c]), 0);
      if (!opmos[c]) begin
        if (last_on[c] == 2) chk("inv_dead_gap", 32'(gap[c] >= int'(dead_time) + 1), 1);
        last_on[c] = 1;
        gap[c]     = 0;
      end else if (onmos[c]) begin
        if (last_on[c] == 1) chk("inv_dead_gap", 32'(gap[c] >= int'(dead_time) + 1), 1);
        last_on[c] = 2;
        gap[c]     = 0;
      end else begin
        gap[c]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    inpb = '1;
    inmb = '1;
    oe   = '0;
    repeat (n) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_opmos"}, 32'(opmos), 32'hf);
    chk({tag, "_onmos"}, 32'(onmos), 0);
    chk({tag, "_cmpmos"}, 32'(cmpmos), 32'hf);
    chk({tag, "_cmnmos"}, 32'(cmnmos), 0);
    chk({tag, "_dead_active"}, 32'(dead_active), 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b0101, 4'b1010, 4'b1111, 4'b0101, 4'b0101, 4'b1111, 4'b0000};
    tbl[1] = '{4'b1010, 4'b0101, 4'b1111, 4'b1010, 4'b1010, 4'b1111, 4'b0000};
    tbl[2] = '{4'b0011, 4'b0101, 4'b1111, 4'b1011, 4'b0010, 4'b1110, 4'b1000};
    tbl[3] = '{4'b0000, 4'b1111, 4'b0110, 4'b1001, 4'b0000, 4'b1111, 4'b0000};
    tbl[4] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    tbl[5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};

    // Reset with random inputs, then idle release.
    rst_n     = 1'b1;
    inpb      = CH'($urandom);
    inmb      = CH'($urandom);
    oe        = CH'($urandom);
    dead_time = 4'd3;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk_reset_vals("rst");
    repeat (3) begin
      inpb = CH'($urandom);
      inmb = CH'($urandom);
      oe   = CH'($urandom);
      tick();
    end
    inpb  = '1;
    inmb  = '1;
    oe    = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_reset_vals("post_rst");
    end

    // Steady-state vector table, dead_time = 3.
    for (int i = 0; i < 8; i++) begin
      inpb = tbl[i].inpb;
      inmb = tbl[i].inmb;
      oe   = tbl[i].oe;
      repeat (12) tick();
      chk($sformatf("tbl%0d_opmos", i), 32'(opmos), 32'(tbl[i].op));
      chk($sformatf("tbl%0d_onmos", i), 32'(onmos), 32'(tbl[i].on));
      chk($sformatf("tbl%0d_cmpmos", i), 32'(cmpmos), 32'(tbl[i].cmp));
      chk($sformatf("tbl%0d_cmnmos", i), 32'(cmnmos), 32'(tbl[i].cmn));
      chk($sformatf("tbl%0d_dead", i), 32'(dead_active), 0);
    end

    // Push entry with dead_time = 3: DEAD on edges 3..6, push from edge 7.
    idle(4);
    dead_time = 4'd3;
    oe[0]     = 1'b1;
    inpb[0]   = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("push_dead_e%0d", e), 32'(dead_active[0]), 32'(e >= 3 && e <= 6));
      chk($sformatf("push_op_e%0d", e), 32'(opmos[0]), 32'(e < 7));
    end

    // Reversal to pull: release on edge 3, pull on edge 7.
    inpb[0] = 1'b1;
    inmb[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("rev_op_e%0d", e), 32'(opmos[0]), 32'(e >= 3));
      chk($sformatf("rev_on_e%0d", e), 32'(onmos[0]), 32'(e >= 7));
      chk($sformatf("rev_dead_e%0d", e), 32'(dead_active[0]), 32'(e >= 3 && e <= 6));
    end

    // oe drops during DEAD: back to HIZ on edge 7, never drives.
    idle(4);
    dead_time = 4'd5;
    oe[0]     = 1'b1;
    inpb[0]   = 1'b0;
    repeat (4) tick();
    oe[0] = 1'b0;
    for (int e = 5; e <= 12; e++) begin
      tick();
      chk($sformatf("abort_dead_e%0d", e), 32'(dead_active[0]), 32'(e <= 6));
      chk($sformatf("abort_op_e%0d", e), 32'(opmos[0]), 1);
    end

    // Target flipped mid-DEAD: reload on edge 7, pull on edge 11.
    idle(4);
    dead_time = 4'd3;
    oe[0]     = 1'b1;
    inpb[0]   = 1'b0;
    repeat (4) tick();
    inpb[0] = 1'b1;
    inmb[0] = 1'b0;
    for (int e = 5; e <= 12; e++) begin
      tick();
      chk($sformatf("flip_dead_e%0d", e), 32'(dead_active[0]), 32'(e <= 10));
      chk($sformatf("flip_on_e%0d", e), 32'(onmos[0]), 32'(e >= 11));
      chk($sformatf("flip_op_e%0d", e), 32'(opmos[0]), 1);
    end

    // dead_time lowered while in DEAD: entry value (5) still governs.
    idle(4);
    dead_time = 4'd5;
    oe[0]     = 1'b1;
    inpb[0]   = 1'b0;
    repeat (4) tick();
    dead_time = 4'd1;
    for (int e = 5; e <= 10; e++) begin
      tick();
      chk($sformatf("dtchg_dead_e%0d", e), 32'(dead_active[0]), 32'(e <= 8));
      chk($sformatf("dtchg_op_e%0d", e), 32'(opmos[0]), 32'(e < 9));
    end

    // dead_time = 0, toggling every 4 cycles: exactly one both-off cycle each.
    dead_time = 4'd0;
    for (int ph = 0; ph < 6; ph++) begin
      int off;
      off     = 0;
      inpb[0] = (ph % 2 == 0);
      inmb[0] = (ph % 2 != 0);
      repeat (4) begin
        tick();
        if (opmos[0] && !onmos[0]) off++;
      end
      chk($sformatf("toggle_off_ph%0d", ph), 32'(off), 1);
    end

    // Both inputs asserted with oe: common-mode NMOS on, drive released.
    inpb[0] = 1'b0;
    inmb[0] = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("cm_cmn_e%0d", e), 32'(cmnmos[0]), 32'(e >= 3));
    end
    chk("cm_op", 32'(opmos[0]), 1);
    chk("cm_on", 32'(onmos[0]), 0);
    chk("cm_cmp", 32'(cmpmos[0]), 1);

    // Random traffic, dead_time constant per block.
    for (int blk = 0; blk < 4; blk++) begin
      idle(4);
      dead_time = DT_W'($urandom_range(0, 4));
      repeat (60) begin
        for (int c = 0; c < CH; c++) begin
          if ($urandom_range(0, 3) == 0) begin
            inpb[c] = 1'($urandom_range(0, 1));
            inmb[c] = 1'($urandom_range(0, 1));
            oe[c]   = ($urandom_range(0, 7) != 0);
          end
        end
        tick();
      end
    end

    // Distinct per-channel drive, then async reset mid-PULL on channel 2.
    idle(4);
    dead_time = 4'd2;
    inpb      = 4'b0110;
    inmb      = 4'b0001;
    oe        = 4'b1111;
    repeat (10) tick();
    chk("indep_opmos", 32'(opmos), 32'b1110);
    chk("indep_onmos", 32'(onmos), 32'b0110);
    chk("indep_cmpmos", 32'(cmpmos), 32'b1111);
    chk("indep_cmnmos", 32'(cmnmos), 32'b1000);
    chk("indep_dead", 32'(dead_active), 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk_reset_vals("async_rst");
    repeat (2) tick();
    idle(0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk_reset_vals("async_rel");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digota_array.md
Name: digota_array

Overview:
- Multi-channel, clocked successor to the combinational digital-OTA output decoder.
- Per channel: synchronises the active-low differential inputs and output enable, decodes the drive target, and sequences the PMOS/NMOS gate controls through a programmable break-before-make dead time.
- Common-mode gate controls are registered alongside.
- Sits between the comparator front ends and the pad-side output transistors; it guarantees the push and pull devices are never on together.

Parameters:
- CHANNELS, 4, number of independent OTA channels.
- DT_W, 4, width of the dead-time setting and counter.
- SYNC_STAGES, 2, synchroniser depth on inpb/inmb/oe (minimum 2).

Ports:
- clk  input  1  single block clock.
- rst_n  input  1  asynchronous, active-low reset.
- inpb  input  CHANNELS  active-low plus input per channel.
- inmb  input  CHANNELS  active-low minus input per channel.
- oe  input  CHANNELS  output enable per channel (active high).
- dead_time  input  DT_W  break-before-make length; sampled on DEAD entry.
- opmos  output  CHANNELS  PMOS gate (0 = PMOS on, push).
- onmos  output  CHANNELS  NMOS gate (1 = NMOS on, pull).
- cmpmos  output  CHANNELS  common-mode PMOS gate (0 = on).
- cmnmos  output  CHANNELS  common-mode NMOS gate (1 = on).
- dead_active  output  CHANNELS  1 while the channel is in DEAD.

Behaviour:
- Reset (async assert, sync release): sync flops for inpb/inmb = 1, sync flops for oe = 0; state = HIZ; count = 0. Outputs: opmos = 1, onmos = 0, cmpmos = 1, cmnmos = 0, dead_active = 0.
- Synchronisation: SYNC_STAGES flops per input. Decode inp = ~inpb_s, inm = ~inmb_s.
- Target decode:
  - oe_s = 0 -> HIZ.
  - inp = 1 and inm = 0 -> PUSH.
  - inp = 0 and inm = 1 -> PULL.
  - inp == inm -> HIZ.
- FSM per channel, states HIZ, DEAD, PUSH, PULL.
  - HIZ: target PUSH/PULL -> DEAD. Latch tgt, load count = dead_time.
  - DEAD, target == HIZ -> HIZ.
  - DEAD, target != tgt (opposite drive) -> stay DEAD, re-latch tgt, reload count = dead_time.
  - DEAD, target == tgt and count == 0 -> tgt state.
  - DEAD, target == tgt and count != 0 -> count-1.
  - PUSH/PULL: target unchanged -> hold. Target HIZ -> HIZ. Opposite drive -> DEAD (latch, load).
- Every entry into PUSH or PULL passes through DEAD, so DEAD lasts dead_time+1 cycles minimum. dead_time = 0 gives exactly 1 both-off cycle.
- Outputs are flops written on the same edge as state:
  - opmos = 0 only in PUSH.
  - onmos = 1 only in PULL.
  - dead_active = 1 only in DEAD.
- Latency (SYNC_STAGES = 2): an input stable before edge 1 reaches the synchronised value at edge 2. The FSM reacts at edge 3: DEAD entry, or drive release. Drive asserts at edge 4+dead_time.
- Drive release is never delayed by the dead time. Loss of target or oe turns the device off on the first FSM edge.
- Common mode, registered from the synced values with the same latency as the FSM reaction:
  - cmpmos = ~(oe_s & ~inp & ~inm).
  - cmnmos = oe_s & inp & inm.
- Invariants, which the bench asserts every cycle:
  - Never (opmos = 0 and onmos = 1).
  - Between any opmos-low interval and any onmos-high interval, at least dead_time+1 cycles with both off.
  - Never cmpmos = 0 together with cmnmos = 1.
- A dead_time change while in DEAD has no effect until the next DEAD entry.
- Reset mid-drive: outputs go to their reset values immediately and asynchronously.
- Channels are fully independent; only dead_time is shared.

Decomposition:
- Package digota_pkg:
  - state enum (HIZ = 2'b00, DEAD = 2'b01, PUSH = 2'b10, PULL = 2'b11).
  - target decode function.
  - output reset constants.
- Sub-module digota_channel: synchroniser, FSM, counter and output flops for one channel.
- digota_array is a generate loop over CHANNELS, with no logic of its own.

Test Plan:
- Reset: rst_n = 0 with random inputs -> all opmos = 1, onmos = 0, cmpmos = 1, cmnmos = 0, dead_active = 0. Hold for 5 cycles after release with inpb = inmb = 1, oe = 0 -> values unchanged.
- Push entry: dead_time = 3, oe = 1, inpb 1->0 before edge 1 -> dead_active = 1 edges 3..6; opmos = 0 from edge 7.
- Reversal: in PUSH, swap to inpb = 1, inmb = 0 -> opmos = 1 at edge 3; onmos = 1 at edge 4+dead_time. No overlap cycle.
- Abort in DEAD: oe drops during DEAD -> HIZ next FSM edge, no drive. Flip target mid-DEAD -> counter reloads; drive asserts dead_time+1 cycles after the flip reaches the FSM.
- dead_time = 0 and common mode: PUSH<->PULL toggling every 4 cycles -> exactly 1 both-off cycle per transition. inpb = inmb = 0 with oe = 1 -> cmnmos = 1, opmos = 1, onmos = 0.
- Async reset mid-PULL on channel 2, with other channels driving -> all channels reset immediately; channels independent before reset, checked with distinct per-channel stimulus.
